// File: rtl/position_trigger_pkg.sv
// pos_trig_pkg: shared FSM states, direction-mode and direction codes for position_trigger
package pos_trig_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, EMIT, GAP} state_t;
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_FWD = 2'b01;
  localparam logic [1:0] MODE_BWD = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;
endpackage

// File: rtl/position_trigger_if.sv
// position_trigger_if: encoder/config inputs (i_*) and trigger/status outputs (o_*) of position_trigger
interface position_trigger_if;
  logic i_sync;
  logic [31:0] i_sync_counter;
  logic i_enable;
  logic [15:0] i_step;
  logic [1:0] i_mode;
  logic i_clr;
  logic o_trig;
  logic o_dir;
  logic [31:0] o_trig_pos;
  logic [31:0] o_trig_count;
  logic o_overrun;
  modport master (
    output i_sync, i_sync_counter, i_enable, i_step, i_mode, i_clr,
    input o_trig, o_dir, o_trig_pos, o_trig_count, o_overrun
  );
  modport slave (
    input i_sync, i_sync_counter, i_enable, i_step, i_mode, i_clr,
    output o_trig, o_dir, o_trig_pos, o_trig_count, o_overrun
  );
endinterface

// File: rtl/position_trigger_pulse_gen.sv
// trig_pulse_gen: TRIG_LEN-cycle pulse then TRIG_GAP idle cycles from one down-counter
// ports: clk, rst_n, i_start (load), i_abort (kill pulse/gap), o_pulse, o_busy
module trig_pulse_gen #(
  parameter int TRIG_LEN = 4,
  parameter int TRIG_GAP = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_abort,
  output logic o_pulse,
  output logic o_busy
);
  localparam int W = $clog2(TRIG_LEN + TRIG_GAP + 1);
  logic [W-1:0] r_cnt;
  // counter runs LEN+GAP-1 .. 0; o_busy drops on the last gap cycle so the
  // owner can re-evaluate on the very next cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= i_abort ? '0 : i_start ? W'(TRIG_LEN + TRIG_GAP - 1) : (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  assign o_pulse = r_cnt >= W'(TRIG_GAP);
  assign o_busy = r_cnt != '0;
endmodule

// File: rtl/position_trigger.sv
// position_trigger: one trigger pulse per programmed step of encoder travel, with catch-up
// ports: clk, rst_n, bus (slave: i_sync/i_sync_counter/i_enable/i_step/i_mode/i_clr in,
//        o_trig/o_dir/o_trig_pos/o_trig_count/o_overrun out)
module position_trigger
  import pos_trig_pkg::*;
#(
  parameter int TRIG_LEN = 4,
  parameter int TRIG_GAP = 1000
) (
  input logic clk,
  input logic rst_n,
  position_trigger_if.slave bus
);
  state_t r_state, w_next;
  logic [31:0] r_cur, r_anchor, r_trig_pos, r_trig_count;
  logic r_dir, r_overrun;
  logic [31:0] w_fwd, w_bwd, w_step, w_new_anchor;
  logic w_f_go, w_b_go, w_start, w_pulse, w_busy, w_track;
  assign w_step = {16'b0, bus.i_step};
  assign w_fwd = r_cur - r_anchor;
  assign w_bwd = r_anchor - r_cur;
  assign w_f_go = (w_step != '0) && !w_fwd[31] && (w_fwd >= w_step);
  assign w_b_go = (w_step != '0) && !w_f_go && !w_bwd[31] && (w_bwd >= w_step);
  assign w_new_anchor = w_f_go ? r_anchor + w_step : r_anchor - w_step;
  assign w_track = bus.i_enable && (r_state == TRACK);
  assign w_start = w_track && ((w_f_go && bus.i_mode[0]) || (w_b_go && bus.i_mode[1]));
  always_comb begin
    w_next = !bus.i_enable ? IDLE :
             (r_state == IDLE) ? TRACK :
             (r_state == TRACK) ? (w_start ? EMIT : TRACK) :
             !w_busy ? TRACK : w_pulse ? EMIT : GAP;
  end
  trig_pulse_gen #(.TRIG_LEN(TRIG_LEN), .TRIG_GAP(TRIG_GAP)) u_pulse (
    .clk(clk), .rst_n(rst_n), .i_start(w_start), .i_abort(!bus.i_enable),
    .o_pulse(w_pulse), .o_busy(w_busy)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cur <= '0;
      r_anchor <= '0;
      r_trig_pos <= '0;
      r_trig_count <= '0;
      r_dir <= DIR_FWD;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.i_sync) r_cur <= bus.i_sync_counter;
      if (bus.i_enable && r_state == IDLE) r_anchor <= r_cur;
      else if (w_track) r_anchor <= (w_step == '0) ? r_cur : (w_f_go || w_b_go) ? w_new_anchor : r_anchor;
      if (w_start) begin
        r_trig_pos <= w_new_anchor;
        r_dir <= w_b_go ? DIR_BWD : DIR_FWD;
      end
      if (bus.i_clr) begin
        r_trig_count <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_start) r_trig_count <= r_trig_count + 1'b1;
        if (bus.i_sync && (r_state == EMIT || r_state == GAP)) r_overrun <= 1'b1;
      end
    end
  assign bus.o_trig = w_pulse;
  assign bus.o_dir = r_dir;
  assign bus.o_trig_pos = r_trig_pos;
  assign bus.o_trig_count = r_trig_count;
  assign bus.o_overrun = r_overrun;
endmodule

// File: tb/tb_position_trigger.sv
// tb_position_trigger: directed self-checking bench for position_trigger
module tb_position_trigger;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int n, r;
  position_trigger_if bus ();
  position_trigger #(.TRIG_LEN(4), .TRIG_GAP(1000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sync(input logic [31:0] v);
    bus.i_sync = 1'b1;
    bus.i_sync_counter = v;
    tick();
    bus.i_sync = 1'b0;
  endtask
  task automatic wait_rise(input string tag, input int max, output int cnt);
    logic prev;
    cnt = 0;
    prev = bus.o_trig;
    do begin
      tick();
      cnt++;
      if (bus.o_trig && !prev) break;
      prev = bus.o_trig;
    end while (cnt < max);
    if (cnt >= max && !(bus.o_trig && !prev)) check({tag, "_timeout"}, 32'(cnt), 32'(max) + 1);
  endtask
  task automatic run(input int cycles, output int rises);
    logic prev;
    rises = 0;
    prev = bus.o_trig;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.o_trig && !prev) rises++;
      prev = bus.o_trig;
    end
  endtask
  task automatic rebase(input logic [31:0] v);
    bus.i_enable = 1'b0;
    tick();
    sync(v);
    bus.i_enable = 1'b1;
    tick();
  endtask
  initial begin
    bus.i_sync = 1'b0;
    bus.i_sync_counter = '0;
    bus.i_enable = 1'b0;
    bus.i_step = 16'd100;
    bus.i_mode = 2'b11;
    bus.i_clr = 1'b0;
    #12;
    check("rst_trig", 32'(bus.o_trig), 0);
    check("rst_count", bus.o_trig_count, 0);
    check("rst_pos", bus.o_trig_pos, 0);
    rst_n = 1'b1;
    tick();
    bus.i_enable = 1'b1;
    tick();
    sync(350);
    wait_rise("f1", 5, n);
    check("f1_lat", 32'(n), 1);
    check("f1_pos", bus.o_trig_pos, 100);
    check("f1_dir", 32'(bus.o_dir), 0);
    check("f1_cnt", bus.o_trig_count, 1);
    run(3, r);
    check("f1_width_hi", 32'(bus.o_trig), 1);
    tick();
    check("f1_width_lo", 32'(bus.o_trig), 0);
    wait_rise("f2", 1100, n);
    check("f2_spacing", 32'(n + 4), 1005);
    check("f2_pos", bus.o_trig_pos, 200);
    wait_rise("f3", 1100, n);
    check("f3_spacing", 32'(n), 1005);
    check("f3_pos", bus.o_trig_pos, 300);
    check("f3_cnt", bus.o_trig_count, 3);
    run(1200, r);
    check("f_no_more", 32'(r), 0);
    bus.i_mode = 2'b10;
    rebase(1000);
    sync(1250);
    run(5, r);
    check("b_silent", 32'(r), 0);
    sync(800);
    wait_rise("b1", 5, n);
    check("b1_pos", bus.o_trig_pos, 1100);
    check("b1_dir", 32'(bus.o_dir), 1);
    for (int k = 0; k < 3; k++) begin
      wait_rise("bk", 1100, n);
      check("bk_pos", bus.o_trig_pos, 32'(1000 - 100 * k));
    end
    check("b_cnt", bus.o_trig_count, 7);
    run(1100, r);
    check("b_no_more", 32'(r), 0);
    bus.i_mode = 2'b11;
    bus.i_step = 16'd64;
    rebase(32'h7FFF_FFC0);
    sync(32'h8000_0010);
    wait_rise("w1", 5, n);
    check("w_pos", bus.o_trig_pos, 32'h8000_0000);
    check("w_dir", 32'(bus.o_dir), 0);
    run(1100, r);
    check("w_single", 32'(r), 0);
    check("w_no_ovr", 32'(bus.o_overrun), 0);
    bus.i_step = 16'd10;
    rebase(0);
    sync(50);
    wait_rise("o1", 5, n);
    check("o1_cnt", bus.o_trig_count, 9);
    run(10, r);
    sync(50);
    check("o_overrun", 32'(bus.o_overrun), 1);
    run(993, r);
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    check("c_trig", 32'(bus.o_trig), 1);
    check("c_cnt", bus.o_trig_count, 0);
    check("c_ovr", 32'(bus.o_overrun), 0);
    for (int k = 0; k < 3; k++) wait_rise("ck", 1100, n);
    check("c_cnt3", bus.o_trig_count, 3);
    run(1100, r);
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    bus.i_step = 16'd100;
    sync(550);
    wait_rise("d1", 5, n);
    check("d1_cnt", bus.o_trig_count, 1);
    wait_rise("d2", 1100, n);
    check("d2_cnt", bus.o_trig_count, 2);
    tick();
    bus.i_enable = 1'b0;
    tick();
    check("d_trig_off", 32'(bus.o_trig), 0);
    run(3000, r);
    check("d_no_more", 32'(r), 0);
    check("d_cnt_held", bus.o_trig_count, 2);
    check("d_pos_held", bus.o_trig_pos, 250);
    bus.i_enable = 1'b1;
    tick();
    run(20, r);
    check("d_reen", 32'(r), 0);
    bus.i_step = 16'd0;
    sync(1234);
    run(5, r);
    check("s0_none", 32'(r), 0);
    bus.i_step = 16'd100;
    run(5, r);
    check("s0_tracked", 32'(r), 0);
    sync(1334);
    wait_rise("s1", 5, n);
    check("s1_pos", bus.o_trig_pos, 1334);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_trig", 32'(bus.o_trig), 0);
    check("ar_cnt", bus.o_trig_count, 0);
    check("ar_pos", bus.o_trig_pos, 0);
    check("ar_dir", 32'(bus.o_dir), 0);
    check("ar_ovr", 32'(bus.o_overrun), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
